// File: rtl/dma_pkg.sv
// Shared types for the DMA stream engine: write/read sequencer states.
package dma_pkg;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RUN  = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/dma_stream_engine_if.sv
// AXI-Stream bundle used for both the inbound (slave) and outbound (master) streams.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready; the source
// holds tdata/tlast stable while tvalid && !tready, and tvalid never waits on tready.
interface dma_stream_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dma_rd_fifo.sv
// Read-return buffer: small synchronous FIFO with first-word-fall-through head and occupancy.
module dma_rd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/dma_stream_engine.sv
// AXI-Stream <-> BRAM port-A sequencer: stream beats become BRAM writes, read jobs
// stream BRAM words back out. Write beats take priority over read issue on port A.
module dma_stream_engine
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_start,
    input  logic [PTR_WIDTH-1:0]  wr_len,
    input  logic                  rd_start,
    input  logic [PTR_WIDTH-1:0]  rd_len,
    dma_stream_engine_if.slave    s_axis,
    dma_stream_engine_if.master   m_axis,
    output logic                  dma_wr_en,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    output logic [PTR_WIDTH-1:0]  dma_write_pointer,
    output logic                  dma_rd_en,
    input  logic [DATA_WIDTH-1:0] dma_rd_data,
    output logic [PTR_WIDTH-1:0]  dma_read_pointer,
    output logic                  wr_busy,
    output logic                  rd_busy,
    output logic                  wr_done,
    output logic                  rd_done,
    output logic                  wr_err,
    output wr_state_t             dbg_wr_state,
    output rd_state_t             dbg_rd_state
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- write sequencer ----------------
    wr_state_t            wr_state_q;
    logic [PTR_WIDTH-1:0] wr_len_q;
    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic                 wr_done_q;
    logic                 wr_err_q;
    logic                 wr_beat;
    logic                 wr_final;

    assign s_axis.tready = (wr_state_q == WR_RUN);
    assign wr_beat       = s_axis.tvalid & s_axis.tready;
    assign wr_final      = (wr_ptr_q == wr_len_q - PTR_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            wr_len_q   <= '0;
            wr_ptr_q   <= '0;
            wr_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            case (wr_state_q)
                WR_IDLE: begin
                    if (wr_start) begin
                        wr_err_q <= 1'b0;
                        wr_ptr_q <= '0;
                        wr_len_q <= wr_len;
                        if (wr_len == '0) wr_done_q  <= 1'b1;
                        else              wr_state_q <= WR_RUN;
                    end
                end
                WR_RUN: begin
                    if (wr_beat) begin
                        wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
                        // A tlast before the final beat truncates the job and is flagged.
                        if (wr_final || s_axis.tlast) begin
                            wr_state_q <= WR_IDLE;
                            wr_done_q  <= 1'b1;
                            if (!wr_final) wr_err_q <= 1'b1;
                        end
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    assign dma_wr_en         = wr_beat;
    assign dma_wr_data       = wr_beat ? s_axis.tdata : '0;
    assign dma_write_pointer = wr_ptr_q;
    assign wr_busy           = (wr_state_q == WR_RUN);
    assign wr_done           = wr_done_q;
    assign wr_err            = wr_err_q;
    assign dbg_wr_state      = wr_state_q;

    // ---------------- read sequencer ----------------
    rd_state_t             rd_state_q;
    logic [PTR_WIDTH-1:0]  rd_len_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic                  rd_done_q;
    logic [RD_LATENCY-1:0] tag_vld_q;
    logic [RD_LATENCY-1:0] tag_last_q;
    logic [CW:0]           inflight;
    logic [CW:0]           occupancy;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  credit_ok;
    logic                  rd_issue;
    logic                  rd_final_issue;
    logic                  out_pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {{CW{1'b0}}, tag_vld_q[i]};
        end
    end

    // Reads in the BRAM pipe count against FIFO space so a return always has a slot.
    assign occupancy      = inflight + {1'b0, fifo_count};
    assign credit_ok      = (occupancy < (CW+1)'(FIFO_DEPTH));
    assign rd_issue       = (rd_state_q == RD_ISSUE) && credit_ok && !wr_beat;
    assign rd_final_issue = (rd_ptr_q == rd_len_q - PTR_WIDTH'(1));
    assign out_pop        = m_axis.tvalid & m_axis.tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_len_q   <= '0;
            rd_ptr_q   <= '0;
            rd_done_q  <= 1'b0;
            tag_vld_q  <= '0;
            tag_last_q <= '0;
        end else begin
            rd_done_q     <= 1'b0;
            tag_vld_q     <= tag_vld_q << 1;
            tag_vld_q[0]  <= rd_issue;
            tag_last_q    <= tag_last_q << 1;
            tag_last_q[0] <= rd_issue && rd_final_issue;
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_start) begin
                        rd_ptr_q <= '0;
                        rd_len_q <= rd_len;
                        if (rd_len == '0) rd_done_q  <= 1'b1;
                        else              rd_state_q <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (rd_issue) begin
                        rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
                        if (rd_final_issue) rd_state_q <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (out_pop && m_axis.tlast) begin
                        rd_state_q <= RD_IDLE;
                        rd_done_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    dma_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (tag_vld_q[RD_LATENCY-1]),
        .push_data_i ({tag_last_q[RD_LATENCY-1], dma_rd_data}),
        .pop_i       (out_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign m_axis.tvalid    = !fifo_empty;
    assign m_axis.tdata     = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign m_axis.tlast     = !fifo_empty && fifo_head[DATA_WIDTH];
    assign dma_rd_en        = rd_issue;
    assign dma_read_pointer = rd_ptr_q;
    assign rd_busy          = (rd_state_q != RD_IDLE);
    assign rd_done          = rd_done_q;
    assign dbg_rd_state     = rd_state_q;

endmodule

// File: tb/tb_dma_stream_engine.sv
// End-to-end bench: engine plus a 2-cycle BRAM model, table-driven jobs and scoreboards.
`timescale 1ns/1ps
module tb_dma_stream_engine;
    import dma_pkg::*;

    localparam int DW = 32;
    localparam int PW = 16;
    localparam int RL = 2;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_start = 1'b0, rd_start = 1'b0;
    logic [PW-1:0] wr_len = '0, rd_len = '0;
    logic          dma_wr_en, dma_rd_en;
    logic [DW-1:0] dma_wr_data, dma_rd_data;
    logic [PW-1:0] dma_write_pointer, dma_read_pointer;
    logic          wr_busy, rd_busy, wr_done, rd_done, wr_err;
    wr_state_t     dbg_wr_state;
    rd_state_t     dbg_rd_state;

    dma_stream_engine_if #(.DATA_WIDTH(DW)) s_if ();
    dma_stream_engine_if #(.DATA_WIDTH(DW)) m_if ();

    dma_stream_engine #(
        .DATA_WIDTH(DW), .PTR_WIDTH(PW), .RD_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_start(wr_start), .wr_len(wr_len), .rd_start(rd_start), .rd_len(rd_len),
        .s_axis(s_if.slave), .m_axis(m_if.master),
        .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data), .dma_write_pointer(dma_write_pointer),
        .dma_rd_en(dma_rd_en), .dma_rd_data(dma_rd_data), .dma_read_pointer(dma_read_pointer),
        .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_done(wr_done), .rd_done(rd_done),
        .wr_err(wr_err), .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
    );

    // ---------------- clock / BRAM model ----------------
    always #5 clk = ~clk;

    logic [DW-1:0] bram [256];
    logic [7:0]    bram_addr_q;
    logic [DW-1:0] bram_dout_q;
    always @(posedge clk) begin
        if (dma_wr_en) bram[dma_write_pointer[7:0]] <= dma_wr_data;
        bram_addr_q <= dma_read_pointer[7:0];
        bram_dout_q <= bram[bram_addr_q];
    end
    assign dma_rd_data = bram_dout_q;

    // ---------------- scoreboard state ----------------
    int n_vec = 0, n_err = 0;
    logic [PW+DW-1:0] wr_exp_q[$];
    logic [DW:0]      rd_exp_q[$];
    logic [DW-1:0]    ref_mem [256];
    logic [PW+DW-1:0] wr_e;
    logic [DW:0]      rd_e;
    int wr_cnt = 0, rd_issue_cnt = 0, out_cnt = 0, wr_done_cnt = 0, rd_done_cnt = 0;
    int rd_idx = 0;
    int ready_mode = 2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outbound ready pattern: 0 always, 1 toggle, 2 held low, 3 random.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = ~m_if.tready;
                2:       m_if.tready = 1'b0;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dma_wr_en) begin
                chk("port_a_excl", {63'b0, dma_rd_en}, 64'd0);
                if (wr_exp_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
                else begin
                    wr_e = wr_exp_q.pop_front();
                    chk("wr_ptr", {48'b0, dma_write_pointer}, {48'b0, wr_e[PW+DW-1:DW]});
                    chk("wr_data", {32'b0, dma_wr_data}, {32'b0, wr_e[DW-1:0]});
                end
                wr_cnt++;
            end
            if (dma_rd_en) begin
                chk("rd_ptr", {48'b0, dma_read_pointer}, 64'(rd_idx));
                rd_idx++;
                rd_issue_cnt++;
            end
            if (m_if.tvalid && m_if.tready) begin
                if (rd_exp_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
                else begin
                    rd_e = rd_exp_q.pop_front();
                    chk("rd_out", {31'b0, m_if.tlast, m_if.tdata}, {31'b0, rd_e});
                end
                out_cnt++;
            end
            if (wr_done) wr_done_cnt++;
            if (rd_done) rd_done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wr_job(input int len, input int beats, input int tlast_idx,
                          input logic [DW-1:0] dbase, input bit same_data);
        int b_done;
        int w;
        bit rdy;
        logic [DW-1:0] d;
        b_done = wr_done_cnt;
        @(posedge clk); #1;
        wr_start = 1'b1; wr_len = PW'(len);
        @(posedge clk); #1;
        wr_start = 1'b0;
        chk("wr_err_clr", {63'b0, wr_err}, 64'd0);
        for (int i = 0; i < beats; i++) begin
            if (same_data)        d = ref_mem[i];
            else if (dbase != '0) d = dbase + DW'(i);
            else                  d = $urandom;
            ref_mem[i] = d;
            wr_exp_q.push_back({PW'(i), d});
            s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = (i == tlast_idx);
            w = 0;
            do begin
                @(negedge clk); rdy = s_if.tready;
                @(posedge clk); #1; w++;
            end while (!rdy && w < 200);
            if (!rdy) chk("wr_beat_timeout", 64'd1, 64'd0);
        end
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        w = 0;
        while (wr_done_cnt == b_done && w < 200) begin @(posedge clk); w++; end
        repeat (2) @(posedge clk);
        #1;
        chk("wr_done_pulses", 64'(wr_done_cnt - b_done), 64'd1);
        chk("wr_busy_end", {63'b0, wr_busy}, 64'd0);
    endtask

    task automatic rd_job(input int len, input int mode);
        int b_done, b_iss, b_out, w;
        b_done = rd_done_cnt; b_iss = rd_issue_cnt; b_out = out_cnt;
        ready_mode = mode;
        for (int i = 0; i < len; i++) rd_exp_q.push_back({(i == len - 1), ref_mem[i]});
        rd_idx = 0;
        @(posedge clk); #1;
        rd_start = 1'b1; rd_len = PW'(len);
        @(posedge clk); #1;
        rd_start = 1'b0;
        w = 0;
        while (rd_done_cnt == b_done && w < 1000) begin @(posedge clk); w++; end
        repeat (2) @(posedge clk);
        #1;
        chk("rd_done_pulses", 64'(rd_done_cnt - b_done), 64'd1);
        chk("rd_issues", 64'(rd_issue_cnt - b_iss), 64'(len));
        chk("rd_outputs", 64'(out_cnt - b_out), 64'(len));
        chk("rd_busy_end", {63'b0, rd_busy}, 64'd0);
        ready_mode = 0;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int            wlen;
        int            beats;
        int            tlast_idx;
        logic [DW-1:0] dbase;
        int            exp_wr;
        logic          exp_err;
        int            rlen;
        int            rmode;
    } vec_t;
    vec_t vecs[6];

    initial begin : main
        int b_wr, b_iss, b_out, b_wd, b_rd;
        vecs[0] = '{8, 8, -1, 32'h0,  8, 1'b0, 8, 3};
        vecs[1] = '{4, 4, -1, 32'hA0, 4, 1'b0, 4, 1};
        vecs[2] = '{4, 2,  1, 32'h0,  2, 1'b1, 2, 0};
        vecs[3] = '{3, 3,  2, 32'h0,  3, 1'b0, 4, 3};
        vecs[4] = '{1, 1, -1, 32'h0,  1, 1'b0, 1, 1};
        vecs[5] = '{0, 0, -1, 32'h0,  0, 1'b0, 0, 0};
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;

        // Reset state
        #12;
        chk("rst_wr_en", {63'b0, dma_wr_en}, 64'd0);
        chk("rst_rd_en", {63'b0, dma_rd_en}, 64'd0);
        chk("rst_tready", {63'b0, s_if.tready}, 64'd0);
        chk("rst_tvalid", {63'b0, m_if.tvalid}, 64'd0);
        chk("rst_busy", {62'b0, wr_busy, rd_busy}, 64'd0);
        chk("rst_flags", {61'b0, wr_done, rd_done, wr_err}, 64'd0);
        chk("rst_ptrs", {32'b0, dma_write_pointer, dma_read_pointer}, 64'd0);
        chk("rst_states", {61'b0, dbg_wr_state, dbg_rd_state}, {61'b0, WR_IDLE, RD_IDLE});
        @(posedge clk); #1; rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            b_wr = wr_cnt;
            wr_job(vecs[v].wlen, vecs[v].beats, vecs[v].tlast_idx, vecs[v].dbase, 1'b0);
            chk("vec_wr_count", 64'(wr_cnt - b_wr), 64'(vecs[v].exp_wr));
            chk("vec_wr_err", {63'b0, wr_err}, {63'b0, vecs[v].exp_err});
            rd_job(vecs[v].rlen, vecs[v].rmode);
        end

        // Read of 8 with outbound stalled: credit limits issue to the FIFO depth.
        b_iss = rd_issue_cnt; b_rd = rd_done_cnt;
        ready_mode = 2;
        for (int i = 0; i < 8; i++) rd_exp_q.push_back({(i == 7), ref_mem[i]});
        rd_idx = 0;
        @(posedge clk); #1; rd_start = 1'b1; rd_len = 16'd8;
        @(posedge clk); #1; rd_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("stall_issues", 64'(rd_issue_cnt - b_iss), 64'(FD));
        chk("stall_tvalid", {63'b0, m_if.tvalid}, 64'd1);
        chk("stall_state", {62'b0, dbg_rd_state}, {62'b0, RD_ISSUE});
        ready_mode = 0;
        for (int w = 0; w < 200 && rd_done_cnt == b_rd; w++) @(posedge clk);
        #1;
        chk("stall_all_issued", 64'(rd_issue_cnt - b_iss), 64'd8);
        chk("stall_done", 64'(rd_done_cnt - b_rd), 64'd1);

        // Zero-length jobs on both sides: done next cycle, no strobes.
        b_wd = wr_done_cnt; b_rd = rd_done_cnt; b_wr = wr_cnt; b_iss = rd_issue_cnt;
        @(posedge clk); #1; wr_start = 1'b1; rd_start = 1'b1; wr_len = '0; rd_len = '0;
        @(posedge clk); #1; wr_start = 1'b0; rd_start = 1'b0;
        chk("len0_dones", {62'b0, wr_done, rd_done}, 64'd3);
        chk("len0_strobes", {62'b0, dma_wr_en, dma_rd_en}, 64'd0);
        chk("len0_busy", {62'b0, wr_busy, rd_busy}, 64'd0);
        @(posedge clk); #1;
        chk("len0_dones_drop", {62'b0, wr_done, rd_done}, 64'd0);
        chk("len0_no_wr", 64'(wr_cnt - b_wr), 64'd0);
        chk("len0_no_rd", 64'(rd_issue_cnt - b_iss), 64'd0);

        // Concurrent jobs; rewrites keep read data independent of ordering.
        fork
            wr_job(3, 3, -1, 32'h0, 1'b1);
            rd_job(3, 0);
        join

        // Reset in the middle of a read with data in flight.
        ready_mode = 2;
        rd_idx = 0;
        @(posedge clk); #1; rd_start = 1'b1; rd_len = 16'd8;
        @(posedge clk); #1; rd_start = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("midrst_out", {62'b0, m_if.tvalid, m_if.tlast}, 64'd0);
        chk("midrst_strobes", {62'b0, dma_wr_en, dma_rd_en}, 64'd0);
        chk("midrst_busy", {62'b0, wr_busy, rd_busy}, 64'd0);
        chk("midrst_ptrs", {32'b0, dma_write_pointer, dma_read_pointer}, 64'd0);
        chk("midrst_state", {62'b0, dbg_rd_state}, {62'b0, RD_IDLE});
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        rd_job(2, 0);

        chk("wr_q_empty", 64'(wr_exp_q.size()), 64'd0);
        chk("rd_q_empty", 64'(rd_exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
